dummy_hls_ip_ctrl_fsm: RTL and testbench

// Control sequencer directly upstream of the dummy HLS IP engine/streamer datapath.

---
 rtl/dummy_hls_ip_ctrl_fsm.sv | 199 +++++++++++++++++++
 tb/tb_dummy_hls_ip_ctrl_fsm.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dummy_hls_ip_ctrl_fsm.sv
// Control sequencer for the dummy HLS IP: per iteration it starts the source/sink streams, kicks the engine,
// waits for both streams to finish and steps the addresses. Optional WAIT watchdog: DUMMY_HLS_IP_TIMEOUT_EN.
module dummy_hls_ip_ctrl_fsm #(
    parameter int CNT_LEN = 1605632,
    parameter int CNT_W   = $clog2(CNT_LEN) + 1,
    parameter int ADDR_W  = 32,
    parameter int ITER_W  = 16
`ifdef DUMMY_HLS_IP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 65536
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [ITER_W-1:0] nb_iter_i,
    input  logic [1:0]        op_type_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [CNT_W-1:0]  in_len_i,
    input  logic [ADDR_W-1:0] in_stride_i,
    input  logic [ADDR_W-1:0] out_addr_i,
    input  logic [CNT_W-1:0]  out_len_i,
    input  logic [ADDR_W-1:0] out_stride_i,
    output logic              src_req_o,
    output logic [ADDR_W-1:0] src_addr_o,
    output logic [CNT_W-1:0]  src_len_o,
    input  logic              src_ack_i,
    input  logic              src_done_i,
    output logic              snk_req_o,
    output logic [ADDR_W-1:0] snk_addr_o,
    output logic [CNT_W-1:0]  snk_len_o,
    input  logic              snk_ack_i,
    input  logic              snk_done_i,
    output logic              eng_clear_o,
    output logic              eng_start_o,
    output logic              eng_enable_o,
    output logic [1:0]        eng_op_type_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ITER_W-1:0] iter_idx_o
);

    typedef enum logic [2:0] {IDLE, START, COMPUTE, WAIT, UPDATEIDX, TERMINATE} state_t;

    state_t            state;
    logic [ITER_W-1:0] nb_iter;
    logic [ADDR_W-1:0] in_stride;
    logic [ADDR_W-1:0] out_stride;
    logic              src_ack_f, snk_ack_f;
    logic              src_done_f, snk_done_f;
    logic              src_got, snk_got, src_fin, snk_fin;
    logic [ITER_W-1:0] iter_nxt;
    logic              cfg_bad;

    assign src_got  = src_ack_f | src_ack_i;
    assign snk_got  = snk_ack_f | snk_ack_i;
    assign src_fin  = src_done_f | src_done_i;
    assign snk_fin  = snk_done_f | snk_done_i;
    assign iter_nxt = iter_idx_o + 1'b1;
    assign cfg_bad  = (nb_iter_i == '0) || (in_len_i == '0) || (out_len_i == '0);

`ifdef DUMMY_HLS_IP_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TO_W-1:0] to_cnt;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            nb_iter       <= '0;
            in_stride     <= '0;
            out_stride    <= '0;
            src_ack_f     <= 1'b0;
            snk_ack_f     <= 1'b0;
            src_done_f    <= 1'b0;
            snk_done_f    <= 1'b0;
            src_req_o     <= 1'b0;
            src_addr_o    <= '0;
            src_len_o     <= '0;
            snk_req_o     <= 1'b0;
            snk_addr_o    <= '0;
            snk_len_o     <= '0;
            eng_clear_o   <= 1'b0;
            eng_start_o   <= 1'b0;
            eng_enable_o  <= 1'b0;
            eng_op_type_o <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            iter_idx_o    <= '0;
`ifdef DUMMY_HLS_IP_TIMEOUT_EN
            to_cnt        <= '0;
`endif
        end else begin
            eng_clear_o <= 1'b0;
            eng_start_o <= 1'b0;
            done_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        nb_iter       <= nb_iter_i;
                        eng_op_type_o <= op_type_i;
                        src_addr_o    <= in_addr_i;
                        src_len_o     <= in_len_i;
                        in_stride     <= in_stride_i;
                        snk_addr_o    <= out_addr_i;
                        snk_len_o     <= out_len_i;
                        out_stride    <= out_stride_i;
                        iter_idx_o    <= '0;
                        if (cfg_bad) begin
                            err_o  <= 1'b1;
                            done_o <= 1'b1;
                            state  <= TERMINATE;
                        end else begin
                            err_o       <= 1'b0;
                            busy_o      <= 1'b1;
                            src_req_o   <= 1'b1;
                            snk_req_o   <= 1'b1;
                            eng_clear_o <= 1'b1;
                            src_ack_f   <= 1'b0;
                            snk_ack_f   <= 1'b0;
                            src_done_f  <= 1'b0;
                            snk_done_f  <= 1'b0;
                            state       <= START;
                        end
                    end
                end
                START: begin
                    if (src_ack_i) begin
                        src_req_o <= 1'b0;
                        src_ack_f <= 1'b1;
                    end
                    if (snk_ack_i) begin
                        snk_req_o <= 1'b0;
                        snk_ack_f <= 1'b1;
                    end
                    // Done flags are cleared on START entry, so a done racing its ack is kept
                    if (src_done_i) src_done_f <= 1'b1;
                    if (snk_done_i) snk_done_f <= 1'b1;
                    if (src_got && snk_got) begin
                        eng_start_o  <= 1'b1;
                        eng_enable_o <= 1'b1;
                        state        <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (src_done_i) src_done_f <= 1'b1;
                    if (snk_done_i) snk_done_f <= 1'b1;
`ifdef DUMMY_HLS_IP_TIMEOUT_EN
                    to_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (src_done_i) src_done_f <= 1'b1;
                    if (snk_done_i) snk_done_f <= 1'b1;
                    if (src_fin && snk_fin) begin
                        eng_enable_o <= 1'b0;
                        state        <= UPDATEIDX;
                    end
`ifdef DUMMY_HLS_IP_TIMEOUT_EN
                    else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                        eng_enable_o <= 1'b0;
                        err_o        <= 1'b1;
                        done_o       <= 1'b1;
                        busy_o       <= 1'b0;
                        state        <= TERMINATE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
`endif
                end
                UPDATEIDX: begin
                    iter_idx_o <= iter_nxt;
                    src_addr_o <= src_addr_o + in_stride;
                    snk_addr_o <= snk_addr_o + out_stride;
                    if (iter_nxt == nb_iter) begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= TERMINATE;
                    end else begin
                        src_req_o   <= 1'b1;
                        snk_req_o   <= 1'b1;
                        eng_clear_o <= 1'b1;
                        src_ack_f   <= 1'b0;
                        snk_ack_f   <= 1'b0;
                        src_done_f  <= 1'b0;
                        snk_done_f  <= 1'b0;
                        state       <= START;
                    end
                end
                TERMINATE: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dummy_hls_ip_ctrl_fsm.sv
// Scoreboard bench for dummy_hls_ip_ctrl_fsm: stimulus pushes expected stream requests, engine starts
// and completions; a negedge monitor pops and compares them as the DUT presents them.
module tb_dummy_hls_ip_ctrl_fsm;
    localparam int CNT_W  = 22;
    localparam int ADDR_W = 32;
    localparam int ITER_W = 16;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic              start_i = 1'b0;
    logic [ITER_W-1:0] nb_iter_i = '0;
    logic [1:0]        op_type_i = '0;
    logic [ADDR_W-1:0] in_addr_i = '0, in_stride_i = '0, out_addr_i = '0, out_stride_i = '0;
    logic [CNT_W-1:0]  in_len_i = '0, out_len_i = '0;
    logic              src_req_o, snk_req_o, src_ack_i = 1'b0, snk_ack_i = 1'b0;
    logic              src_done_i = 1'b0, snk_done_i = 1'b0;
    logic [ADDR_W-1:0] src_addr_o, snk_addr_o;
    logic [CNT_W-1:0]  src_len_o, snk_len_o;
    logic              eng_clear_o, eng_start_o, eng_enable_o, busy_o, done_o, err_o;
    logic [1:0]        eng_op_type_o;
    logic [ITER_W-1:0] iter_idx_o;

    dummy_hls_ip_ctrl_fsm #(
        .CNT_W(CNT_W), .ADDR_W(ADDR_W), .ITER_W(ITER_W)
`ifdef DUMMY_HLS_IP_TIMEOUT_EN
        , .TIMEOUT_CYC(32)
`endif
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .nb_iter_i(nb_iter_i), .op_type_i(op_type_i),
        .in_addr_i(in_addr_i), .in_len_i(in_len_i), .in_stride_i(in_stride_i),
        .out_addr_i(out_addr_i), .out_len_i(out_len_i), .out_stride_i(out_stride_i),
        .src_req_o(src_req_o), .src_addr_o(src_addr_o), .src_len_o(src_len_o),
        .src_ack_i(src_ack_i), .src_done_i(src_done_i),
        .snk_req_o(snk_req_o), .snk_addr_o(snk_addr_o), .snk_len_o(snk_len_o),
        .snk_ack_i(snk_ack_i), .snk_done_i(snk_done_i),
        .eng_clear_o(eng_clear_o), .eng_start_o(eng_start_o), .eng_enable_o(eng_enable_o),
        .eng_op_type_o(eng_op_type_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .iter_idx_o(iter_idx_o)
    );

    always #5 clk = ~clk;

    typedef struct {logic [ADDR_W-1:0] addr; logic [CNT_W-1:0] len; logic [ITER_W-1:0] iter;} req_t;
    typedef struct {logic [1:0] op; logic [ITER_W-1:0] iter;} eng_t;
    typedef struct {logic err; logic [ITER_W-1:0] iter; int cyc;} done_t;

    req_t  src_q[$], snk_q[$];
    eng_t  eng_q[$];
    done_t done_q[$];
    int checks = 0, failures = 0, cyc = 0, n_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none (t=%0t)", name, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Stream responders: ack after ack_dly cycles of req; done done_dly cycles after ack (0 = same cycle)
    int src_ack_dly = 0, src_done_dly = 0, snk_ack_dly = 0, snk_done_dly = 0;
    bit src_hold = 0, snk_hold = 0;
    int src_rc = 0, src_dc = 0, snk_rc = 0, snk_dc = 0;

    always begin
        @(posedge clk); #2;
        src_done_i = 1'b0;
        if (rst_i) begin
            src_ack_i = 1'b0; src_rc = 0; src_dc = 0;
        end else begin
            if (src_dc > 0) begin src_dc--; if (src_dc == 0) src_done_i = 1'b1; end
            if (src_req_o && src_rc >= src_ack_dly) begin
                src_ack_i = 1'b1;
                if (!src_hold) begin
                    if (src_done_dly == 0) src_done_i = 1'b1; else src_dc = src_done_dly;
                end
            end else src_ack_i = 1'b0;
            src_rc = src_req_o ? src_rc + 1 : 0;
        end
    end

    always begin
        @(posedge clk); #2;
        snk_done_i = 1'b0;
        if (rst_i) begin
            snk_ack_i = 1'b0; snk_rc = 0; snk_dc = 0;
        end else begin
            if (snk_dc > 0) begin snk_dc--; if (snk_dc == 0) snk_done_i = 1'b1; end
            if (snk_req_o && snk_rc >= snk_ack_dly) begin
                snk_ack_i = 1'b1;
                if (!snk_hold) begin
                    if (snk_done_dly == 0) snk_done_i = 1'b1; else snk_dc = snk_done_dly;
                end
            end else snk_ack_i = 1'b0;
            snk_rc = snk_req_o ? snk_rc + 1 : 0;
        end
    end

    req_t  mr;
    eng_t  me;
    done_t md;
    always @(negedge clk) begin
        if (!rst_i) begin
            if (src_req_o && src_ack_i) begin
                if (src_q.size() == 0) unexpected("src_req");
                else begin
                    mr = src_q.pop_front();
                    check("src_addr", 64'(src_addr_o), 64'(mr.addr));
                    check("src_len", 64'(src_len_o), 64'(mr.len));
                    check("src_iter", 64'(iter_idx_o), 64'(mr.iter));
                end
            end
            if (snk_req_o && snk_ack_i) begin
                if (snk_q.size() == 0) unexpected("snk_req");
                else begin
                    mr = snk_q.pop_front();
                    check("snk_addr", 64'(snk_addr_o), 64'(mr.addr));
                    check("snk_len", 64'(snk_len_o), 64'(mr.len));
                    check("snk_iter", 64'(iter_idx_o), 64'(mr.iter));
                end
            end
            if (eng_start_o) begin
                if (eng_q.size() == 0) unexpected("eng_start");
                else begin
                    me = eng_q.pop_front();
                    check("eng_op", 64'(eng_op_type_o), 64'(me.op));
                    check("eng_iter", 64'(iter_idx_o), 64'(me.iter));
                    check("eng_enable", 64'(eng_enable_o), 64'd1);
                end
            end
            if (done_o) begin
                n_done++;
                if (done_q.size() == 0) unexpected("done");
                else begin
                    md = done_q.pop_front();
                    check("done_err", 64'(err_o), 64'(md.err));
                    check("done_iter", 64'(iter_idx_o), 64'(md.iter));
                    check("done_busy", 64'(busy_o), 64'd0);
                    if (md.cyc >= 0) check("done_cycle", 64'(cyc), 64'(md.cyc));
                end
            end
        end
    end

    // Issues a start (caller guarantees the DUT is idle) and queues every expected response
    task automatic do_start(input logic [ITER_W-1:0] nb, input logic [1:0] op,
                            input logic [ADDR_W-1:0] ia, input logic [CNT_W-1:0] il,
                            input logic [ADDR_W-1:0] is, input logic [ADDR_W-1:0] oa,
                            input logic [CNT_W-1:0] ol, input logic [ADDR_W-1:0] os,
                            input int exp_off);
        req_t r;
        eng_t e;
        done_t d;
        int k;
        nb_iter_i = nb; op_type_i = op; in_addr_i = ia; in_len_i = il; in_stride_i = is;
        out_addr_i = oa; out_len_i = ol; out_stride_i = os;
        start_i = 1'b1;
        k = cyc;
        if (nb == 0 || il == 0 || ol == 0) begin
            d.err = 1'b1; d.iter = '0; d.cyc = k + 1;
        end else begin
            for (int i = 0; i < int'(nb); i++) begin
                r.addr = ia + ADDR_W'(i) * is; r.len = il; r.iter = ITER_W'(i); src_q.push_back(r);
                r.addr = oa + ADDR_W'(i) * os; r.len = ol; snk_q.push_back(r);
                e.op = op; e.iter = ITER_W'(i); eng_q.push_back(e);
            end
            d.err = 1'b0; d.iter = nb; d.cyc = (exp_off >= 0) ? k + exp_off : -1;
        end
        done_q.push_back(d);
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && n_done < target; i++) @(posedge clk);
        #1;
        check("done_seen", 64'(n_done >= target), 64'd1);
    endtask

    task automatic check_queues(input string name);
        check(name, 64'(src_q.size() + snk_q.size() + eng_q.size() + done_q.size()), 64'd0);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_ctl"}, 64'({src_req_o, snk_req_o, eng_clear_o, eng_start_o, eng_enable_o,
                                   busy_o, done_o, err_o}), 64'd0);
        check({name, "_data"}, 64'({src_addr_o, snk_addr_o}), 64'd0);
        check({name, "_misc"}, 64'({src_len_o, snk_len_o, eng_op_type_o, iter_idx_o}), 64'd0);
    endtask

    task automatic set_dly(input int sa, input int sd, input int ka, input int kd);
        src_ack_dly = sa; src_done_dly = sd; snk_ack_dly = ka; snk_done_dly = kd;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

    initial begin
        int nd;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        check_idle_outputs("reset");

        // Single iteration, immediate ack/done: done_o five cycles after start
        set_dly(0, 0, 0, 0);
        do_start(1, 2'd2, 32'h100, 16, 32'h40, 32'h2000, 16, 32'h40, 5);
        wait_done(1, 20);
        check_queues("q_single");

        // Three iterations with a busy-time start and config change that must be ignored
        do_start(3, 2'd1, 32'h1000, 24, 32'h40, 32'h8000, 32, 32'h100, 13);
        repeat (2) @(posedge clk);
        #1;
        start_i = 1'b1; in_addr_i = 32'hDEAD_0000; nb_iter_i = 7; op_type_i = 2'd3;
        @(posedge clk); #1 start_i = 1'b0;
        wait_done(2, 40);
        check_queues("q_three");

        // Sink finishes 10 cycles before source, then both in the same cycle
        set_dly(0, 12, 0, 2);
        do_start(2, 2'd0, 32'h4000, 8, 32'h10, 32'h5000, 8, 32'h20, -1);
        wait_done(3, 80);
        check_queues("q_snk_first");
        set_dly(0, 3, 0, 3);
        do_start(2, 2'd3, 32'h6000, 5, 32'h8, 32'h7000, 6, 32'h8, -1);
        wait_done(4, 40);
        check_queues("q_same_done");

        // Acks at different times
        set_dly(3, 1, 0, 4);
        do_start(1, 2'd1, 32'hA000, 9, 32'h0, 32'hB000, 9, 32'h0, -1);
        wait_done(5, 40);
        check_queues("q_ack_skew");

        // Zero length / zero iteration: immediate error completion, then a clean run clears err_o
        set_dly(0, 0, 0, 0);
        do_start(2, 2'd0, 32'h100, 16, 32'h40, 32'h200, 0, 32'h40, 1);
        wait_done(6, 10);
        check("err_sticky", 64'(err_o), 64'd1);
        do_start(0, 2'd0, 32'h100, 16, 32'h40, 32'h200, 16, 32'h40, 1);
        wait_done(7, 10);
        do_start(1, 2'd2, 32'h300, 4, 32'h40, 32'h400, 4, 32'h40, 5);
        wait_done(8, 20);
        check("err_cleared", 64'(err_o), 64'd0);
        check_queues("q_zero");

        // Address wrap at 2^ADDR_W
        do_start(2, 2'd1, 32'hFFFF_FFC0, 3, 32'h40, 32'h10, 3, 32'hFFFF_FFF0, 9);
        wait_done(9, 30);
        check_queues("q_wrap");

        // Start on the TERMINATE cycle is ignored
        do_start(1, 2'd0, 32'h800, 2, 32'h0, 32'h900, 2, 32'h0, 5);
        nd = 0;
        for (int i = 0; i < 20 && !done_o; i++) begin @(posedge clk); #1; end
        check("term_seen", 64'(done_o), 64'd1);
        start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("term_start_busy", 64'(busy_o), 64'd0);
        check_queues("q_term");

        // Reset during WAIT of the second iteration: no done, then a fresh clean job
        set_dly(0, 6, 0, 6);
        nd = n_done;
        do_start(3, 2'd2, 32'h1000, 16, 32'h40, 32'h2000, 16, 32'h40, -1);
        for (int i = 0; i < 60 && !(iter_idx_o == 1 && eng_enable_o && !eng_start_o); i++) begin
            @(posedge clk); #1;
        end
        check("wait_iter1", 64'(iter_idx_o), 64'd1);
        rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        check_idle_outputs("midreset");
        check("midreset_left", 64'({16'(src_q.size()), 16'(eng_q.size()), 16'(done_q.size())}),
              64'({16'd1, 16'd1, 16'd1}));
        src_q.delete(); snk_q.delete(); eng_q.delete(); done_q.delete();
        repeat (20) @(posedge clk);
        #1;
        check("midreset_nodone", 64'(n_done), 64'(nd));
        set_dly(0, 0, 0, 0);
        do_start(2, 2'd1, 32'h3000, 7, 32'h80, 32'h4000, 7, 32'h80, 9);
        wait_done(nd + 1, 30);
        check_queues("q_fresh");

        // Sink done withheld: watchdog completion with error, or an indefinite WAIT
        snk_hold = 1;
        nd = n_done;
`ifdef DUMMY_HLS_IP_TIMEOUT_EN
        do_start(1, 2'd3, 32'h5000, 4, 32'h0, 32'h6000, 4, 32'h0, -1);
        done_q[done_q.size()-1].err = 1'b1;
        done_q[done_q.size()-1].iter = '0;
        done_q[done_q.size()-1].cyc = cyc - 1 + 35;
        wait_done(nd + 1, 80);
        check("timeout_err", 64'(err_o), 64'd1);
        check_queues("q_timeout");
`else
        do_start(1, 2'd3, 32'h5000, 4, 32'h0, 32'h6000, 4, 32'h0, -1);
        repeat (200) @(posedge clk);
        #1;
        check("hold_busy", 64'({busy_o, eng_enable_o, err_o}), 64'b110);
        check("hold_nodone", 64'(n_done), 64'(nd));
        rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        check("hold_left", 64'(done_q.size()), 64'd1);
        done_q.delete();
        check_queues("q_hold");
`endif
        snk_hold = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
